// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between IF and MEM, with MEM at fixed priority
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                flush_if_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_done_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_done_o,
    output logic                ram_stall_valid_if_o,
    output logic                ram_stall_valid_mem_o,
    output logic                bus_valid_o,
    input  logic                bus_ready_i,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);
    typedef enum logic [2:0] {IDLE, IF_ADDR, IF_RESP, MEM_ADDR, MEM_RESP} state_t;
    state_t state;
    logic   drop;
    logic   mem_elig;
    logic   if_elig;
    // a requester is eligible (and stalls the pipe) while asserted and not in its done cycle
    assign mem_elig              = mem_req_i & ~mem_done_o;
    assign if_elig               = if_req_i & ~if_done_o & ~flush_if_i;
    assign ram_stall_valid_mem_o = mem_elig;
    assign ram_stall_valid_if_o  = if_elig;
    // one transaction at a time: grant, address handshake, response, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drop        <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_elig) begin
                        state       <= MEM_ADDR;
                        bus_valid_o <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        bus_wstrb_o <= mem_we_i ? mem_wstrb_i : '0;
                    end else if (if_elig) begin
                        state       <= IF_ADDR;
                        bus_valid_o <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        bus_wstrb_o <= '0;
                    end
                end
                IF_ADDR, MEM_ADDR: begin
                    if (flush_if_i && state == IF_ADDR) drop <= 1'b1;
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        state       <= (state == IF_ADDR) ? IF_RESP : MEM_RESP;
                    end
                end
                IF_RESP: begin
                    if (flush_if_i) drop <= 1'b1;
                    if (bus_rvalid_i) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (!(drop || flush_if_i)) begin
                            if_rdata_o <= bus_rdata_i;
                            if_done_o  <= 1'b1;
                        end
                    end
                end
                MEM_RESP: begin
                    if (bus_rvalid_i) begin
                        state       <= IDLE;
                        mem_rdata_o <= bus_rdata_i;
                        mem_done_o  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        flush_if_i;
    logic [63:0] if_rdata_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [7:0]  mem_wstrb_i;
    logic [63:0] mem_rdata_o;
    logic        mem_done_o;
    logic        ram_stall_valid_if_o;
    logic        ram_stall_valid_mem_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_wstrb_o;
    logic        bus_rvalid_i;
    logic [63:0] bus_rdata_i;
    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_if_i(flush_if_i),
        .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_stall_valid_if_o(ram_stall_valid_if_o), .ram_stall_valid_mem_o(ram_stall_valid_mem_o),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req_i = 0; if_addr_i = 0; flush_if_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_wstrb_i = 0;
        bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    endtask

    task automatic test_reset;
        tick;
        rst = 1;
        idle_inputs();
        tick;
        @(negedge clk);
        n_tests++;
        if ({bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o, if_done_o, mem_done_o,
             if_rdata_o, mem_rdata_o, ram_stall_valid_if_o, ram_stall_valid_mem_o} !== '0)
            begin n_fail++; $display("FAIL reset_values: got valid=%b addr=%h done=%b/%b", bus_valid_o, bus_addr_o, if_done_o, mem_done_o); end
        tick;
        rst = 0;
        @(negedge clk);
        n_tests++;
        if ({bus_valid_o, if_done_o, mem_done_o} !== 3'b000)
            begin n_fail++; $display("FAIL reset_release_idle: got %b required 000", {bus_valid_o, if_done_o, mem_done_o}); end
    endtask

    task automatic test_if_zero_wait;
        for (int c = 0; c < 5; c++) begin
            tick;
            if_req_i = (c <= 3); if_addr_i = 32'h8000_0000;
            bus_ready_i = 1; bus_rvalid_i = (c == 2); bus_rdata_i = 64'h13;
            @(negedge clk);
            n_tests++;
            if ({bus_valid_o, if_done_o, ram_stall_valid_if_o} !== {c == 1, c == 3, c <= 2})
                begin n_fail++; $display("FAIL if_zero_wait c%0d: got valid/done/stall=%b required %b", c, {bus_valid_o, if_done_o, ram_stall_valid_if_o}, {c == 1, c == 3, c <= 2}); end
            if (c == 1) begin
                n_tests++;
                if ({bus_we_o, bus_addr_o, bus_wstrb_o} !== {1'b0, 32'h8000_0000, 8'h00})
                    begin n_fail++; $display("FAIL if_zero_wait_cmd: got we=%b addr=%h strb=%h", bus_we_o, bus_addr_o, bus_wstrb_o); end
            end
            if (c == 3) begin
                n_tests++;
                if (if_rdata_o !== 64'h13)
                    begin n_fail++; $display("FAIL if_zero_wait_data: got %h required 13", if_rdata_o); end
            end
        end
    endtask

    task automatic test_wait_states;
        for (int c = 0; c < 9; c++) begin
            tick;
            mem_req_i = (c <= 7); mem_we_i = 1; mem_addr_i = 32'h8000_1000;
            mem_wdata_i = 64'hDEAD_BEEF; mem_wstrb_i = 8'h0F;
            bus_ready_i = (c == 4); bus_rvalid_i = (c == 6); bus_rdata_i = 0;
            @(negedge clk);
            n_tests++;
            if ({bus_valid_o, mem_done_o, ram_stall_valid_mem_o} !== {c >= 1 && c <= 4, c == 7, c <= 6})
                begin n_fail++; $display("FAIL wait_states c%0d: got valid/done/stall=%b required %b", c, {bus_valid_o, mem_done_o, ram_stall_valid_mem_o}, {c >= 1 && c <= 4, c == 7, c <= 6}); end
            if (c >= 1 && c <= 4) begin
                n_tests++;
                if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o} !== {1'b1, 32'h8000_1000, 64'hDEAD_BEEF, 8'h0F})
                    begin n_fail++; $display("FAIL wait_states_fields c%0d: got we=%b addr=%h wdata=%h strb=%h", c, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o); end
            end
        end
    endtask

    task automatic test_contention;
        for (int c = 0; c < 8; c++) begin
            tick;
            mem_req_i = (c <= 3); mem_we_i = 1; mem_addr_i = 32'h8000_2000;
            mem_wdata_i = 64'h1122; mem_wstrb_i = 8'hFF;
            if_req_i = (c <= 6); if_addr_i = 32'h8000_0040;
            bus_ready_i = 1; bus_rvalid_i = (c == 2 || c == 5); bus_rdata_i = (c == 2) ? 64'hAA : 64'hBB;
            @(negedge clk);
            n_tests++;
            if ({bus_valid_o, mem_done_o, if_done_o, ram_stall_valid_if_o} !== {c == 1 || c == 4, c == 3, c == 6, c <= 5})
                begin n_fail++; $display("FAIL contention c%0d: got valid/mdone/idone/istall=%b required %b", c, {bus_valid_o, mem_done_o, if_done_o, ram_stall_valid_if_o}, {c == 1 || c == 4, c == 3, c == 6, c <= 5}); end
            if (c == 1 || c == 4) begin
                n_tests++;
                if ({bus_we_o, bus_addr_o, bus_wstrb_o} !== ((c == 1) ? {1'b1, 32'h8000_2000, 8'hFF} : {1'b0, 32'h8000_0040, 8'h00}))
                    begin n_fail++; $display("FAIL contention_order c%0d: got we=%b addr=%h strb=%h", c, bus_we_o, bus_addr_o, bus_wstrb_o); end
            end
            if (c == 6) begin
                n_tests++;
                if (if_rdata_o !== 64'hBB)
                    begin n_fail++; $display("FAIL contention_if_data: got %h required bb", if_rdata_o); end
            end
        end
    endtask

    task automatic test_if_flush;
        for (int c = 0; c < 9; c++) begin
            tick;
            mem_req_i = 0;
            if_req_i = (c <= 7); if_addr_i = (c <= 2) ? 32'h8000_0100 : 32'h8000_0200; flush_if_i = (c == 2);
            bus_ready_i = 1; bus_rvalid_i = (c == 3 || c == 6); bus_rdata_i = (c == 3) ? 64'h55 : 64'h66;
            @(negedge clk);
            n_tests++;
            if ({bus_valid_o, if_done_o, ram_stall_valid_if_o} !== {c == 1 || c == 5, c == 7, c != 2 && c < 7})
                begin n_fail++; $display("FAIL if_flush c%0d: got valid/done/stall=%b required %b", c, {bus_valid_o, if_done_o, ram_stall_valid_if_o}, {c == 1 || c == 5, c == 7, c != 2 && c < 7}); end
            if (c >= 4) begin
                n_tests++;
                if (if_rdata_o !== ((c == 7 || c == 8) ? 64'h66 : 64'hBB))
                    begin n_fail++; $display("FAIL if_flush_data c%0d: got %h", c, if_rdata_o); end
            end
            if (c == 5) begin
                n_tests++;
                if (bus_addr_o !== 32'h8000_0200)
                    begin n_fail++; $display("FAIL if_flush_regrant: got addr %h required 80000200", bus_addr_o); end
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 8; c++) begin
            tick;
            rst = (c == 3);
            if_req_i = 0; flush_if_i = 0;
            mem_req_i = (c <= 3 || c >= 6); mem_we_i = 0; mem_addr_i = (c <= 3) ? 32'h8000_3000 : 32'h8000_4000;
            bus_ready_i = 1; bus_rvalid_i = (c == 4); bus_rdata_i = 64'h77;
            @(negedge clk);
            if (c == 4 || c == 5) begin
                n_tests++;
                if ({bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o, if_done_o, mem_done_o, if_rdata_o, mem_rdata_o} !== '0)
                    begin n_fail++; $display("FAIL reset_mid c%0d: got valid=%b addr=%h mdone=%b mrdata=%h irdata=%h", c, bus_valid_o, bus_addr_o, mem_done_o, mem_rdata_o, if_rdata_o); end
            end
            if (c == 7) begin
                n_tests++;
                if ({bus_valid_o, bus_addr_o} !== {1'b1, 32'h8000_4000})
                    begin n_fail++; $display("FAIL reset_mid_idle: got valid=%b addr=%h", bus_valid_o, bus_addr_o); end
            end
        end
    endtask

    task automatic test_random;
        int          mp;
        bit          mw, md, mel, iel, mem_fin, if_fin;
        bit          e_valid, e_we, e_ifd, e_memd, e_sif, e_smem;
        logic [31:0] e_addr;
        logic [63:0] e_wdata, e_ifr, e_memr;
        logic [7:0]  e_wstrb;
        tick;
        rst = 1;
        idle_inputs();
        mp = 0; mw = 0; md = 0; mem_fin = 0; if_fin = 0;
        {e_valid, e_we, e_ifd, e_memd} = '0;
        e_addr = 0; e_wdata = 0; e_ifr = 0; e_memr = 0; e_wstrb = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick;
            rst = 0;
            if (mem_fin || (!mem_req_i && $urandom % 4 == 0)) begin
                mem_req_i = mem_fin ? 1'($urandom % 2) : 1'b1;
                mem_we_i = 1'($urandom % 2); mem_addr_i = $urandom;
                mem_wdata_i = {$urandom, $urandom}; mem_wstrb_i = 8'($urandom);
            end
            if (if_fin || (!if_req_i && $urandom % 3 == 0)) begin
                if_req_i = if_fin ? 1'($urandom % 2) : 1'b1;
                if_addr_i = $urandom;
            end
            flush_if_i = ($urandom % 8 == 0);
            bus_ready_i = 1'($urandom % 2);
            bus_rvalid_i = ($urandom % 3 == 0);
            bus_rdata_i = {$urandom, $urandom};
            @(negedge clk);
            e_smem = mem_req_i & ~e_memd;
            e_sif = if_req_i & ~e_ifd & ~flush_if_i;
            n_tests++;
            if ({bus_valid_o, if_done_o, mem_done_o, ram_stall_valid_if_o, ram_stall_valid_mem_o, if_rdata_o, mem_rdata_o} !==
                {e_valid, e_ifd, e_memd, e_sif, e_smem, e_ifr, e_memr})
                begin n_fail++; $display("FAIL random_ctl cyc%0d: got v=%b id=%b md=%b si=%b sm=%b ir=%h mr=%h required v=%b id=%b md=%b si=%b sm=%b ir=%h mr=%h",
                    cyc, bus_valid_o, if_done_o, mem_done_o, ram_stall_valid_if_o, ram_stall_valid_mem_o, if_rdata_o, mem_rdata_o,
                    e_valid, e_ifd, e_memd, e_sif, e_smem, e_ifr, e_memr); end
            if (e_valid) begin
                n_tests++;
                if ({bus_we_o, bus_addr_o, bus_wstrb_o, e_we ? bus_wdata_o : 64'h0} !== {e_we, e_addr, e_wstrb, e_we ? e_wdata : 64'h0})
                    begin n_fail++; $display("FAIL random_cmd cyc%0d: got we=%b addr=%h strb=%h wdata=%h required we=%b addr=%h strb=%h wdata=%h",
                        cyc, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o, e_we, e_addr, e_wstrb, e_wdata); end
            end
            mem_fin = e_memd;
            if_fin = e_ifd | flush_if_i;
            mel = e_smem;
            iel = e_sif;
            e_ifd = 0;
            e_memd = 0;
            if (mp == 0) begin
                md = 0;
                if (mel) begin
                    mp = 1; mw = 1; e_valid = 1; e_we = mem_we_i; e_addr = mem_addr_i;
                    e_wdata = mem_wdata_i; e_wstrb = mem_we_i ? mem_wstrb_i : 8'h00;
                end else if (iel) begin
                    mp = 1; mw = 0; e_valid = 1; e_we = 0; e_addr = if_addr_i; e_wdata = 0; e_wstrb = 0;
                end
            end else begin
                if (!mw && flush_if_i) md = 1;
                if (mp == 1 && bus_ready_i) begin
                    mp = 2; e_valid = 0;
                end else if (mp == 2 && bus_rvalid_i) begin
                    mp = 0;
                    if (mw) begin e_memr = bus_rdata_i; e_memd = 1; end
                    else if (!md) begin e_ifr = bus_rdata_i; e_ifd = 1; end
                    md = 0;
                end
            end
        end
        tick;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_if_zero_wait();
        test_wait_states();
        test_contention();
        test_if_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single external memory port between the instruction-fetch requester (IF) and the load/store requester (MEM). It sequences one transaction at a time over a valid/ready address channel plus a response channel. It also drives the `ram_stall_valid_if` and `ram_stall_valid_mem` stall requests consumed by the pipeline controller. MEM has fixed priority over IF, consistent with the pipeline rule that later stages win.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width; strobe width is `DATA_W/8`

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req_i`  in  1  IF read request, level, held until `if_done_o` or flush
- `if_addr_i`  in  ADDR_W  IF fetch address
- `flush_if_i`  in  1  IF request cancelled (jump/trap flush)
- `if_rdata_o`  out  DATA_W  fetched data, valid when `if_done_o`
- `if_done_o`  out  1  one-cycle completion pulse for IF
- `mem_req_i`  in  1  MEM request, level, held until `mem_done_o`
- `mem_we_i`  in  1  1 = write, 0 = read
- `mem_addr_i`  in  ADDR_W  MEM address
- `mem_wdata_i`  in  DATA_W  MEM write data
- `mem_wstrb_i`  in  DATA_W/8  MEM byte strobes
- `mem_rdata_o`  out  DATA_W  load data, valid when `mem_done_o`
- `mem_done_o`  out  1  one-cycle completion pulse for MEM
- `ram_stall_valid_if_o`  out  1  stall request for IF
- `ram_stall_valid_mem_o`  out  1  stall request for MEM
- `bus_valid_o`  out  1  address/command valid
- `bus_ready_i`  in  1  slave accepts command
- `bus_we_o`  out  1  command type
- `bus_addr_o`  out  ADDR_W  command address
- `bus_wdata_o`  out  DATA_W  write data
- `bus_wstrb_o`  out  DATA_W/8  write strobes; 0 for reads
- `bus_rvalid_i`  in  1  response valid; read data, or write acknowledge
- `bus_rdata_i`  in  DATA_W  response data

## Operation
- FSM states: IDLE, IF_ADDR, IF_RESP, MEM_ADDR, MEM_RESP.
- IDLE arbitration:
  - An eligible request is one that is asserted and whose `*_done_o` is not high in this cycle. This prevents re-granting a requester in the cycle it sees completion.
  - Eligible MEM goes to MEM_ADDR; otherwise eligible IF goes to IF_ADDR, unless `flush_if_i` is high in that cycle.
- On a grant, the command fields (`bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_wstrb_o`) are registered from the winner. IF is always a read with strobe 0.
- *_ADDR states:
  - `bus_valid_o` is 1 and the fields are held stable.
  - When `bus_ready_i` is 1, the FSM moves to *_RESP and `bus_valid_o` falls next cycle.
  - `bus_valid_o` is never withdrawn before the handshake.
- *_RESP states:
  - The FSM waits for `bus_rvalid_i`.
  - On `bus_rvalid_i`, `bus_rdata_i` is registered into `*_rdata_o`, `*_done_o` pulses next cycle, and the FSM goes to IDLE.
- IF flush:
  - `flush_if_i` in IF_ADDR or IF_RESP sets a drop flag.
  - The bus transaction still completes. At completion, `if_done_o` is suppressed and `if_rdata_o` is unchanged.
  - The drop flag clears on entry to IDLE.
  - `flush_if_i` in IDLE or during MEM states has no effect.
- Stall outputs, combinational:
  - `ram_stall_valid_mem_o = mem_req_i & ~mem_done_o`
  - `ram_stall_valid_if_o = if_req_i & ~if_done_o & ~flush_if_i`
- `bus_rvalid_i` in IDLE or *_ADDR is ignored.
- `mem_rdata_o` updates on writes as well, with don't-care data.

## Timing
- Reset values:
  - state IDLE, drop flag 0
  - `bus_valid_o`, `bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_wstrb_o` all 0
  - `if_done_o`, `mem_done_o` 0; `if_rdata_o`, `mem_rdata_o` 0
- Reset mid-transaction: the FSM returns to IDLE and no done pulse is issued. A late `bus_rvalid_i` is ignored.
- Minimum latency with zero-wait slave, request seen in IDLE at cycle 0:
  - `bus_valid_o` in cycle 1, with `bus_ready_i` accepted in cycle 1
  - RESP and `bus_rvalid_i` in cycle 2
  - `*_done_o` in cycle 3, with data valid in cycle 3
- Back-to-back: the FSM is in IDLE during the done cycle. The next grant is evaluated in that cycle, so the next `bus_valid_o` is at done+1.
- Simultaneous `if_req_i` and `mem_req_i` in IDLE: MEM is served first. IF keeps stalling and is granted in the IDLE cycle that coincides with `mem_done_o`, if no new eligible MEM request is present.
- Each `*_done_o` is exactly one cycle wide.

## Test plan
- Zero-wait IF read:
  - Stimulus: `if_req_i`=1, addr 0x8000_0000, `bus_ready_i`=1, `bus_rvalid_i` in the first RESP cycle with data 0x13.
  - Required: `bus_valid_o` at cycle 1 with addr 0x8000_0000, `if_done_o` at cycle 3, `if_rdata_o`=0x13, `ram_stall_valid_if_o` low in cycle 3.
- Wait states:
  - Stimulus: MEM write, addr 0x8000_1000, wdata 0xDEAD_BEEF, strb 0x0F; `bus_ready_i` low for 3 cycles; ack 2 cycles later.
  - Required: fields stable while `bus_valid_o` is high, `mem_done_o` is one pulse, stall high until the done cycle.
- Contention:
  - Stimulus: `if_req_i` and `mem_req_i` rise together.
  - Required: MEM transaction first. IF `bus_valid_o` at `mem_done_o`+1 cycle. IF stall held throughout.
- IF flush in IF_RESP:
  - Stimulus: flush during the wait, then response 0x55.
  - Required: no `if_done_o`, `if_rdata_o` unchanged, FSM back to IDLE, a new IF request is granted normally.
- Reset:
  - Stimulus: `rst` asserted in MEM_RESP, then `bus_rvalid_i` in the next cycle.
  - Required: all outputs 0, no `mem_done_o`, state IDLE.
